// File: rtl/dram_read_gather_pkg.sv
// Shared configuration and FSM state type for the DRAM read gather block.
package dram_read_gather_pkg;
    localparam int VSIZE          = 32;
    localparam int CSIZE          = 32;
    localparam int GLOBAL_ADDR_BW = 32;
    localparam int DATA_BW        = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} drg_state_t;
endpackage

// File: rtl/dram_read_gather_lane_scatter.sv
// Combinational lane matcher: flags pending lanes that fall in the current line
// and selects each lane's word out of that line's data.
module drg_lane_scatter #(
    parameter int VSIZE = 32,
    parameter int CSIZE = 32,
    parameter int GBW   = 32,
    parameter int DBW   = 16
) (
    input  logic [GBW-1:0]              line_addr,
    input  logic [VSIZE-1:0][GBW-1:0]   addr,
    input  logic [VSIZE-1:0]            pend,
    input  logic [CSIZE-1:0][DBW-1:0]   line_data,
    output logic [VSIZE-1:0]            hit,
    output logic [VSIZE-1:0][DBW-1:0]   word
);
    localparam int CS_BW = $clog2(CSIZE);

    generate
        for (genvar gi = 0; gi < VSIZE; gi++) begin : g_lane
            assign hit[gi]  = pend[gi] && (addr[gi][GBW-1:CS_BW] == line_addr[GBW-1:CS_BW]);
            assign word[gi] = line_data[addr[gi][CS_BW-1:0]];
        end
    endgenerate
endmodule

// File: rtl/dram_read_gather.sv
// Gathers one warp of lane reads by fetching each distinct DRAM line once, in lane order.
// Optional last-line buffer: define DRAM_READ_GATHER_LINE_CACHE_EN.
module dram_read_gather #(
    parameter int VSIZE = dram_read_gather_pkg::VSIZE,
    parameter int CSIZE = dram_read_gather_pkg::CSIZE,
    parameter int GBW   = dram_read_gather_pkg::GLOBAL_ADDR_BW,
    parameter int DBW   = dram_read_gather_pkg::DATA_BW
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        addrval_rdy,
    output logic                        addrval_ack,
    input  logic [VSIZE-1:0][GBW-1:0]   i_address,
    input  logic [VSIZE-1:0]            i_valid,
    output logic                        dramra_rdy,
    input  logic                        dramra_ack,
    output logic [GBW-1:0]              o_dramra,
    input  logic                        dramrd_rdy,
    output logic                        dramrd_ack,
    input  logic [CSIZE-1:0][DBW-1:0]   i_dramrd,
    output logic                        dat_rdy,
    input  logic                        dat_ack,
    output logic [VSIZE-1:0][DBW-1:0]   o_dat
);
    import dram_read_gather_pkg::*;

    localparam int CS_BW = $clog2(CSIZE);
    localparam int VS_BW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    drg_state_t                 state_reg, state_next;
    logic [VSIZE-1:0][GBW-1:0]  addr_reg;
    logic [VSIZE-1:0]           pend_reg;
    logic [GBW-1:0]             line_reg;
    logic [VSIZE-1:0][DBW-1:0]  dat_reg;

    logic [VS_BW-1:0]           first_lane;
    logic [GBW-1:0]             issue_line, scatter_line;
    logic [CSIZE-1:0][DBW-1:0]  scatter_data;
    logic [VSIZE-1:0]           hit;
    logic [VSIZE-1:0][DBW-1:0]  lane_word;
    logic                       cache_hit;
    logic                       scatter_en;

    // Lowest pending lane decides the next line, giving strictly ascending lane order.
    always_comb begin
        first_lane = '0;
        for (int j = VSIZE - 1; j >= 0; j--) begin
            if (pend_reg[j]) first_lane = VS_BW'(j);
        end
    end

    assign issue_line = {addr_reg[first_lane][GBW-1:CS_BW], {CS_BW{1'b0}}};

`ifdef DRAM_READ_GATHER_LINE_CACHE_EN
    logic [CSIZE-1:0][DBW-1:0]  cache_data_reg;
    logic [GBW-1:0]             cache_tag_reg;
    logic                       cache_vld_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cache_vld_reg <= 1'b0;
        else if (state_reg == WAIT && dramrd_rdy)
            cache_vld_reg <= 1'b1;
    end

    // Data and tag are qualified by the valid bit, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (state_reg == WAIT && dramrd_rdy) begin
            cache_data_reg <= i_dramrd;
            cache_tag_reg  <= line_reg;
        end
    end

    assign cache_hit    = (state_reg == ISSUE) && cache_vld_reg && (cache_tag_reg == issue_line);
    assign scatter_data = (state_reg == ISSUE) ? cache_data_reg : i_dramrd;
`else
    assign cache_hit    = 1'b0;
    assign scatter_data = i_dramrd;
`endif

    assign scatter_line = (state_reg == ISSUE) ? issue_line : line_reg;
    assign scatter_en   = ((state_reg == WAIT) && dramrd_rdy) || cache_hit;

    drg_lane_scatter #(
        .VSIZE(VSIZE), .CSIZE(CSIZE), .GBW(GBW), .DBW(DBW)
    ) u_scatter (
        .line_addr (scatter_line),
        .addr      (addr_reg),
        .pend      (pend_reg),
        .line_data (scatter_data),
        .hit       (hit),
        .word      (lane_word)
    );

    always_comb begin
        state_next  = state_reg;
        addrval_ack = 1'b0;
        dramra_rdy  = 1'b0;
        dramrd_ack  = 1'b0;
        dat_rdy     = 1'b0;
        case (state_reg)
            IDLE: begin
                addrval_ack = addrval_rdy && !i_rst;
                if (addrval_rdy) state_next = (i_valid == '0) ? OUT : ISSUE;
            end
            ISSUE: begin
                if (cache_hit) begin
                    state_next = ((pend_reg & ~hit) == '0) ? OUT : ISSUE;
                end else begin
                    dramra_rdy = 1'b1;
                    if (dramra_ack) state_next = WAIT;
                end
            end
            WAIT: begin
                dramrd_ack = dramrd_rdy;
                if (dramrd_rdy) state_next = ((pend_reg & ~hit) == '0) ? OUT : ISSUE;
            end
            OUT: begin
                dat_rdy = 1'b1;
                if (dat_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_dramra = dramra_rdy ? issue_line : '0;
    assign o_dat    = dat_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            pend_reg  <= '0;
            line_reg  <= '0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && addrval_rdy) begin
                addr_reg <= i_address;
                pend_reg <= i_valid;
                dat_reg  <= '0;
            end
            if (state_reg == ISSUE) line_reg <= issue_line;
            if (scatter_en) begin
                pend_reg <= pend_reg & ~hit;
                for (int j = 0; j < VSIZE; j++) begin
                    if (hit[j]) dat_reg[j] <= lane_word[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_read_gather.sv
// Directed bench for dram_read_gather with a small DRAM responder whose word at address a is 0x5A00 ^ a.
module tb_dram_read_gather;
    localparam int VS  = 32;
    localparam int CS  = 32;
    localparam int GBW = 32;
    localparam int DBW = 16;
    localparam int W   = VS * DBW;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     addrval_rdy = 1'b0;
    logic                     addrval_ack;
    logic [VS-1:0][GBW-1:0]   i_address = '0;
    logic [VS-1:0]            i_valid = '0;
    logic                     dramra_rdy;
    logic                     dramra_ack;
    logic [GBW-1:0]           o_dramra;
    logic                     dramrd_rdy;
    logic                     dramrd_ack;
    logic [CS-1:0][DBW-1:0]   i_dramrd;
    logic                     dat_rdy;
    logic                     dat_ack = 1'b0;
    logic [VS-1:0][DBW-1:0]   o_dat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_read_gather dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .addrval_rdy (addrval_rdy),
        .addrval_ack (addrval_ack),
        .i_address   (i_address),
        .i_valid     (i_valid),
        .dramra_rdy  (dramra_rdy),
        .dramra_ack  (dramra_ack),
        .o_dramra    (o_dramra),
        .dramrd_rdy  (dramrd_rdy),
        .dramrd_ack  (dramrd_ack),
        .i_dramrd    (i_dramrd),
        .dat_rdy     (dat_rdy),
        .dat_ack     (dat_ack),
        .o_dat       (o_dat)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DRAM responder: programmable stall before request ack and before response.
    int          ra_stall = 0;
    int          rd_stall = 0;
    int          flush_req = 0;
    int          req_cnt = 0;
    int          viol = 0;
    logic [31:0] req_log [$];

    int          m_ra_cnt = 0, m_rd_cnt = 0, m_flush_seen = 0;
    bit          m_have = 0, m_ra_fire = 0, m_rd_fire = 0, m_ra_wait = 0;
    logic [31:0] m_line = '0, m_ra_addr = '0, m_held = '0;

    initial begin
        dramra_ack = 1'b0;
        dramrd_rdy = 1'b0;
        i_dramrd   = '0;
        forever begin
            @(negedge clk);
            if (m_ra_fire) begin
                req_log.push_back(m_ra_addr);
                req_cnt++;
                m_line   = m_ra_addr;
                m_have   = 1'b1;
                m_rd_cnt = rd_stall;
            end
            if (m_rd_fire || flush_req != m_flush_seen) begin
                m_have       = 1'b0;
                dramrd_rdy   = 1'b0;
                m_flush_seen = flush_req;
            end
            if (m_ra_wait && (!dramra_rdy || o_dramra !== m_held)) viol++;
            if (dramra_rdy) begin
                if (m_ra_cnt > 0) begin
                    dramra_ack = 1'b0;
                    m_ra_cnt--;
                end else begin
                    dramra_ack = 1'b1;
                end
            end else begin
                dramra_ack = 1'b0;
                m_ra_cnt   = ra_stall;
            end
            if (m_have && !dramrd_rdy) begin
                if (m_rd_cnt > 0) m_rd_cnt--;
                else begin
                    dramrd_rdy = 1'b1;
                    for (int w = 0; w < CS; w++) i_dramrd[w] = 16'h5A00 ^ 16'(m_line + 32'(w));
                end
            end
            #1;
            m_ra_fire = dramra_rdy && dramra_ack;
            m_ra_addr = o_dramra;
            m_rd_fire = dramrd_rdy && dramrd_ack;
            m_ra_wait = dramra_rdy && !dramra_ack;
            m_held    = o_dramra;
        end
    end

    // acc_cyc is the cycle in which the address handshake is asserted.
    task automatic send_warp(input logic [VS-1:0][GBW-1:0] a, input logic [VS-1:0] v,
                             output int acc_cyc);
        int n = 0;
        @(negedge clk);
        i_address   = a;
        i_valid     = v;
        addrval_rdy = 1'b1;
        #1;
        while (!addrval_ack && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("addrval_ack", addrval_ack, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        addrval_rdy = 1'b0;
    endtask

    task automatic recv_warp(input int stall, output logic [W-1:0] dat, output int rdy_cyc);
        int n = 0;
        logic [W-1:0] first;
        bit unstable = 0;
        @(negedge clk);
        while (!dat_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("dat_rdy_seen", dat_rdy, 1);
        rdy_cyc = cyc;
        first   = o_dat;
        repeat (stall) begin
            @(negedge clk);
            if (!dat_rdy || o_dat !== first) unstable = 1;
        end
        check("dat_stable", unstable, 0);
        dat_ack = 1'b1;
        @(posedge clk);
        #1;
        dat_ack = 1'b0;
        dat = first;
    endtask

    logic [VS-1:0][GBW-1:0] a;
    logic [VS-1:0][DBW-1:0] exp_dat;
    logic [W-1:0]           got_dat;
    int acc, rdy, base, order_err, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addrval_ack", addrval_ack, 0);
        check("rst_dramra_rdy", dramra_rdy, 0);
        check("rst_dramrd_ack", dramrd_ack, 0);
        check("rst_dat_rdy", dat_rdy, 0);
        check("rst_o_dramra", o_dramra, 0);
        check("rst_o_dat", o_dat, 0);
        rst = 1'b0;

        // 1) all lanes in line 0x100
        base = req_cnt;
        for (int j = 0; j < VS; j++) begin
            a[j] = 32'h100 + 32'(j);
            exp_dat[j] = 16'h5B00 + 16'(j);
        end
        send_warp(a, '1, acc);
        recv_warp(0, got_dat, rdy);
        check("t1_latency", rdy - acc, 3);
        check("t1_req_cnt", req_cnt - base, 1);
        check("t1_req_addr", req_log[base], 32'h100);
        check("t1_dat", got_dat, exp_dat);

        // 2) one distinct line per lane
        base = req_cnt;
        for (int j = 0; j < VS; j++) begin
            a[j] = 32'h20 * 32'(j);
            exp_dat[j] = 16'h5A00 ^ 16'(32'h20 * j);
        end
        send_warp(a, '1, acc);
        recv_warp(0, got_dat, rdy);
        check("t2_req_cnt", req_cnt - base, VS);
        order_err = 0;
        for (int j = 0; j < VS && base + j < req_log.size(); j++)
            if (req_log[base + j] !== 32'h20 * 32'(j)) order_err++;
        check("t2_req_order", order_err, 0);
        check("t2_latency", rdy - acc, 65);
        check("t2_dat", got_dat, exp_dat);

        // 3) empty mask
        base = req_cnt;
        send_warp(a, '0, acc);
        recv_warp(0, got_dat, rdy);
        check("t3_req_cnt", req_cnt - base, 0);
        check("t3_latency", rdy - acc, 1);
        check("t3_dat", got_dat, 0);

        // 4) mask 0xA5, all lanes at 0x3F
        base = req_cnt;
        exp_dat = '0;
        for (int j = 0; j < VS; j++) a[j] = 32'h3F;
        exp_dat[0] = 16'h5A3F; exp_dat[2] = 16'h5A3F;
        exp_dat[5] = 16'h5A3F; exp_dat[7] = 16'h5A3F;
        send_warp(a, 32'hA5, acc);
        recv_warp(0, got_dat, rdy);
        check("t4_req_cnt", req_cnt - base, 1);
        check("t4_req_addr", req_log[base], 32'h20);
        check("t4_dat", got_dat, exp_dat);

        // 5) backpressure on every handshake, two lines
        base = req_cnt;
        ra_stall = 5;
        rd_stall = 5;
        viol = 0;
        for (int j = 0; j < VS; j++) begin
            a[j] = 32'h200 + 32'(2 * j);
            exp_dat[j] = 16'h5800 + 16'(2 * j);
        end
        send_warp(a, '1, acc);
        recv_warp(5, got_dat, rdy);
        check("t5_req_cnt", req_cnt - base, 2);
        check("t5_req0", req_log[base], 32'h200);
        check("t5_req1", req_log[base + 1], 32'h220);
        check("t5_ra_stable", viol, 0);
        check("t5_dat", got_dat, exp_dat);
        ra_stall = 0;

        // 6) reset while waiting for a response
        rd_stall = 3;
        base = req_cnt;
        for (int j = 0; j < VS; j++) begin
            a[j] = 32'h300 + 32'(j);
            exp_dat[j] = 16'h5900 + 16'(j);
        end
        @(negedge clk);
        i_address = a;
        i_valid = '1;
        addrval_rdy = 1'b1;
        n = 0;
        while (req_cnt == base && n < 50) begin
            @(negedge clk);
            #2;
            if (addrval_ack === 1'b0) addrval_rdy = 1'b0;
            n++;
        end
        addrval_rdy = 1'b0;
        check("t6_req_seen", req_cnt - base, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_o_dat", o_dat, 0);
        check("t6_rst_dramra_rdy", dramra_rdy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("t6_stale_present", dramrd_rdy, 1);
        check("t6_stale_not_acked", dramrd_ack, 0);
        check("t6_idle_dat_rdy", dat_rdy, 0);
        flush_req++;
        rd_stall = 0;
        @(negedge clk);
        base = req_cnt;
        send_warp(a, '1, acc);
        recv_warp(0, got_dat, rdy);
        check("t6_fresh_req_cnt", req_cnt - base, 1);
        check("t6_fresh_req_addr", req_log[base], 32'h300);
        check("t6_fresh_dat", got_dat, exp_dat);

        // 7) two warps on line 0x40
        base = req_cnt;
        for (int j = 0; j < VS; j++) begin
            a[j] = 32'h40 + 32'(j);
            exp_dat[j] = 16'h5A40 + 16'(j);
        end
        send_warp(a, '1, acc);
        recv_warp(0, got_dat, rdy);
        check("t7_dat_a", got_dat, exp_dat);
        send_warp(a, '1, acc);
        recv_warp(0, got_dat, rdy);
        check("t7_dat_b", got_dat, exp_dat);
`ifdef DRAM_READ_GATHER_LINE_CACHE_EN
        check("t7_req_cnt", req_cnt - base, 1);
`else
        check("t7_req_cnt", req_cnt - base, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
